// File: rtl/mips_cpu_mem_arbiter.sv
// Shared-bus sequencer: fetch, decode, optional data access, one-cycle commit.
// Define MEM_ARB_PERF_EN to add the perf_cycles/perf_instrs/perf_stalls counters.
module mips_cpu_mem_arbiter #(
  parameter int unsigned MAX_WAIT     = 16,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        cpu_clk_enable,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_error
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instrs,
  output logic [31:0] perf_stalls
`endif
);

  localparam logic [31:0] RV_UNUSED = RESET_VECTOR;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_DATA,
    S_COMMIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_instr;
  logic [31:0] r_rdata;
  logic [31:0] r_wait;
  logic        w_xfer;
  logic        w_done;
  logic        w_timeout;
  logic        w_enter;

  // FETCH right after reset has no strobe yet; that cycle only launches it
  assign w_xfer = (r_state == S_FETCH && r_read) || (r_state == S_DATA);
  assign w_done = w_xfer && !waitrequest;
  assign w_timeout = (MAX_WAIT != 0) && w_xfer && waitrequest
                  && (r_wait == MAX_WAIT - 1);
  assign w_enter = (w_next != r_state);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_timeout)   w_next = S_ERROR;
        else if (w_done) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (data_read && data_write)      w_next = S_ERROR;
        else if (data_read || data_write) w_next = S_DATA;
        else                              w_next = S_COMMIT;
      end
      S_DATA: begin
        if (w_timeout)   w_next = S_ERROR;
        else if (w_done) w_next = S_COMMIT;
      end
      S_COMMIT: w_next = cpu_active ? S_FETCH : S_HALT;
      S_HALT:   w_next = S_HALT;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_instr <= '0;
      r_rdata <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_FETCH && (w_enter || !r_read)) begin
        r_read  <= 1'b1;
        r_addr  <= instr_address;
        r_wait  <= '0;
      end else if (w_next == S_DATA && w_enter) begin
        r_read  <= data_read;
        r_write <= data_write;
        r_addr  <= data_address;
        r_wdata <= data_writedata;
        r_wait  <= '0;
      end else if (w_enter) begin
        r_read  <= 1'b0;
        r_write <= 1'b0;
      end else if (w_xfer && waitrequest) begin
        r_wait  <= r_wait + 32'd1;
      end
      if (r_state == S_FETCH && w_done)
        r_instr <= readdata;
      if (r_state == S_DATA && r_read && !waitrequest)
        r_rdata <= readdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_pcyc;
  logic [31:0] r_pins;
  logic [31:0] r_pstl;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pcyc <= '0;
      r_pins <= '0;
      r_pstl <= '0;
    end else begin
      if (r_state != S_HALT && r_state != S_ERROR)
        r_pcyc <= r_pcyc + 32'd1;
      if (r_state == S_COMMIT)
        r_pins <= r_pins + 32'd1;
      if (w_xfer && waitrequest)
        r_pstl <= r_pstl + 32'd1;
    end
  end

  assign perf_cycles = r_pcyc;
  assign perf_instrs = r_pins;
  assign perf_stalls = r_pstl;
`endif

  assign instr_readdata = r_instr;
  assign data_readdata  = r_rdata;
  assign cpu_clk_enable = (r_state == S_COMMIT);
  assign address        = r_addr;
  assign read           = r_read;
  assign write          = r_write;
  assign writedata      = r_wdata;
  assign byteenable     = 4'hF;
  assign bus_error      = (r_state == S_ERROR);

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for mips_cpu_mem_arbiter with a small wait-state bus responder.
// Each task drives one scenario and checks hand-computed values inline.
module tb_mips_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_active = 1'b1;
  logic [31:0] instr_address = 32'hBFC00000;
  logic [31:0] instr_readdata;
  logic [31:0] data_address = 32'h0000_0F00;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_writedata = 32'h0;
  logic [31:0] data_readdata;
  logic        cpu_clk_enable;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;

  int          n_checks = 0;
  int          n_fail = 0;
  int          fetch_wait = 0;
  int          data_wait = 0;
  logic        stuck = 1'b0;
  int          stall_cnt = 0;
  logic [31:0] instr_data = 32'h24020005;
  logic [31:0] ld_data = 32'hDEADBEEF;
  logic [31:0] wd_seen;
  logic [3:0]  be_seen;

  mips_cpu_mem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_active     (cpu_active),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .cpu_clk_enable (cpu_clk_enable),
    .address        (address),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .byteenable     (byteenable),
    .waitrequest    (waitrequest),
    .readdata       (readdata),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  // Stall the first N strobed cycles of each transfer
  assign waitrequest = stuck || ((read || write) &&
    (stall_cnt < ((address == data_address) ? data_wait : fetch_wait)));
  assign readdata = (address == data_address) ? ld_data : instr_data;

  always @(posedge clk) begin
    if (!(read || write) || !waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  task automatic wait_read_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starts on the negedge of a fetch's first strobed cycle, stops on commit
  task automatic run_instr(output int ccyc, output int nrd, output int nwr,
                           output int nda, output bit stable);
    logic [31:0] pa;
    bit ps;
    int n;
    ccyc = 0; nrd = 0; nwr = 0; nda = 0; stable = 1'b1;
    ps = 1'b0; pa = '0; n = 0;
    while (ccyc == 0 && n < 40) begin
      if (n > 0) @(negedge clk);
      n++;
      if (read) nrd++;
      if (write) begin
        nwr++;
        wd_seen = writedata;
        be_seen = byteenable;
      end
      if ((read || write) && address == data_address) nda++;
      if ((read || write) && ps && address !== pa) stable = 1'b0;
      ps = read || write;
      pa = address;
      if (cpu_clk_enable) ccyc = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (read !== 1'b0) begin
      n_fail++; $display("FAIL reset_read got %b want 0", read);
    end
    n_checks++;
    if (write !== 1'b0) begin
      n_fail++; $display("FAIL reset_write got %b want 0", write);
    end
    n_checks++;
    if (cpu_clk_enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_cke got %b want 0", cpu_clk_enable);
    end
    n_checks++;
    if (bus_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_berr got %b want 0", bus_error);
    end
    n_checks++;
    if (instr_readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_instr got %h want 0", instr_readdata);
    end
    n_checks++;
    if (data_readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h want 0", data_readdata);
    end
    n_checks++;
    if (address !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr got %h want 0", address);
    end
    n_checks++;
    if (writedata !== 32'h0) begin
      n_fail++; $display("FAIL reset_wdata got %h want 0", writedata);
    end
    n_checks++;
    if (byteenable !== 4'hF) begin
      n_fail++; $display("FAIL byteenable got %h want f", byteenable);
    end
  endtask

  task automatic test_alu();
    int c, r, w, d;
    bit s, ok;
    instr_address = 32'hBFC00000;
    instr_data = 32'h24020005;
    reset = 1'b1;
    wait_read_rise(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL alu_start got %b want 1", ok);
    end
    n_checks++;
    if (address !== 32'hBFC00000) begin
      n_fail++; $display("FAIL alu_addr got %h want bfc00000", address);
    end
    run_instr(c, r, w, d, s);
    n_checks++;
    if (c !== 3) begin
      n_fail++; $display("FAIL alu_commit_cycle got %0d want 3", c);
    end
    n_checks++;
    if (r !== 1) begin
      n_fail++; $display("FAIL alu_read_cycles got %0d want 1", r);
    end
    n_checks++;
    if (instr_readdata !== 32'h24020005) begin
      n_fail++; $display("FAIL alu_instr got %h want 24020005", instr_readdata);
    end
    @(negedge clk);
    n_checks++;
    if (cpu_clk_enable !== 1'b0) begin
      n_fail++; $display("FAIL alu_cke_pulse got %b want 0", cpu_clk_enable);
    end
    n_checks++;
    if (read !== 1'b1) begin
      n_fail++; $display("FAIL alu_next_fetch got %b want 1", read);
    end
  endtask

  task automatic test_load();
    int c, r, w, d;
    bit s;
    data_read = 1'b1;
    data_address = 32'h00001000;
    ld_data = 32'hDEADBEEF;
    data_wait = 2;
    run_instr(c, r, w, d, s);
    n_checks++;
    if (c !== 6) begin
      n_fail++; $display("FAIL load_commit_cycle got %0d want 6", c);
    end
    n_checks++;
    if (d !== 3) begin
      n_fail++; $display("FAIL load_addr_cycles got %0d want 3", d);
    end
    n_checks++;
    if (s !== 1'b1) begin
      n_fail++; $display("FAIL load_addr_stable got %b want 1", s);
    end
    n_checks++;
    if (r !== 4) begin
      n_fail++; $display("FAIL load_read_cycles got %0d want 4", r);
    end
    n_checks++;
    if (data_readdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_data got %h want deadbeef", data_readdata);
    end
    data_read = 1'b0;
    data_wait = 0;
    @(negedge clk);
  endtask

  task automatic test_store();
    int c, r, w, d;
    bit s;
    data_write = 1'b1;
    data_address = 32'h00002000;
    data_writedata = 32'h12345678;
    wd_seen = '0;
    be_seen = '0;
    run_instr(c, r, w, d, s);
    n_checks++;
    if (c !== 4) begin
      n_fail++; $display("FAIL store_commit_cycle got %0d want 4", c);
    end
    n_checks++;
    if (w !== 1) begin
      n_fail++; $display("FAIL store_write_cycles got %0d want 1", w);
    end
    n_checks++;
    if (r !== 1) begin
      n_fail++; $display("FAIL store_read_cycles got %0d want 1", r);
    end
    n_checks++;
    if (wd_seen !== 32'h12345678) begin
      n_fail++; $display("FAIL store_wdata got %h want 12345678", wd_seen);
    end
    n_checks++;
    if (be_seen !== 4'hF) begin
      n_fail++; $display("FAIL store_be got %h want f", be_seen);
    end
    data_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c, r, w, d;
    bit s;
    fetch_wait = 1;
    run_instr(c, r, w, d, s);
    n_checks++;
    if (c !== 4) begin
      n_fail++; $display("FAIL b2b_wait_commit got %0d want 4", c);
    end
    n_checks++;
    if (r !== 2) begin
      n_fail++; $display("FAIL b2b_wait_reads got %0d want 2", r);
    end
    fetch_wait = 0;
    @(negedge clk);
    run_instr(c, r, w, d, s);
    n_checks++;
    if (c !== 3) begin
      n_fail++; $display("FAIL b2b_commit got %0d want 3", c);
    end
    @(negedge clk);
  endtask

  task automatic test_halt();
    int c, r, w, d, nr, nc;
    bit s, ok;
    cpu_active = 1'b0;
    run_instr(c, r, w, d, s);
    n_checks++;
    if (c !== 3) begin
      n_fail++; $display("FAIL halt_commit got %0d want 3", c);
    end
    nr = 0; nc = 0;
    repeat (20) begin
      @(negedge clk);
      if (read || write) nr++;
      if (cpu_clk_enable) nc++;
    end
    n_checks++;
    if (nr !== 0) begin
      n_fail++; $display("FAIL halt_strobes got %0d want 0", nr);
    end
    n_checks++;
    if (nc !== 0) begin
      n_fail++; $display("FAIL halt_cke got %0d want 0", nc);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cpu_active = 1'b1;
    wait_read_rise(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL halt_restart got %b want 1", ok);
    end
    run_instr(c, r, w, d, s);
    n_checks++;
    if (c !== 3) begin
      n_fail++; $display("FAIL halt_resume_commit got %0d want 3", c);
    end
  endtask

  task automatic test_timeout();
    int n, nr, nc, ne;
    bit ok;
    reset = 1'b0;
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_read_rise(ok);
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (!read) break;
      n++;
    end
    n_checks++;
    if (n !== 16) begin
      n_fail++; $display("FAIL timeout_read_cycles got %0d want 16", n);
    end
    n_checks++;
    if (bus_error !== 1'b1) begin
      n_fail++; $display("FAIL timeout_berr got %b want 1", bus_error);
    end
    nr = 0; nc = 0; ne = 0;
    repeat (10) begin
      @(negedge clk);
      if (read || write) nr++;
      if (cpu_clk_enable) nc++;
      if (!bus_error) ne++;
    end
    n_checks++;
    if (nr + nc + ne !== 0) begin
      n_fail++;
      $display("FAIL timeout_sticky got strobes=%0d cke=%0d noerr=%0d want 0",
               nr, nc, ne);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_read_rise(ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (read !== 1'b1) begin
      n_fail++; $display("FAIL mid_read_before got %b want 1", read);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (read !== 1'b0) begin
      n_fail++; $display("FAIL mid_read_drop got %b want 0", read);
    end
    n_checks++;
    if ({write, cpu_clk_enable, bus_error} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_outputs got %b want 000",
               {write, cpu_clk_enable, bus_error});
    end
    n_checks++;
    if (address !== 32'h0) begin
      n_fail++; $display("FAIL mid_addr got %h want 0", address);
    end
    stuck = 1'b0;
  endtask

  task automatic test_both_error();
    int nr, nw, nc;
    bit ok;
    data_read = 1'b1;
    data_write = 1'b1;
    reset = 1'b1;
    wait_read_rise(ok);
    nr = 1; nw = 0; nc = 0;
    repeat (12) begin
      @(negedge clk);
      if (read) nr++;
      if (write) nw++;
      if (cpu_clk_enable) nc++;
    end
    n_checks++;
    if (nr !== 1 || nw !== 0) begin
      n_fail++;
      $display("FAIL both_strobes got rd=%0d wr=%0d want rd=1 wr=0", nr, nw);
    end
    n_checks++;
    if (nc !== 0) begin
      n_fail++; $display("FAIL both_cke got %0d want 0", nc);
    end
    n_checks++;
    if (bus_error !== 1'b1) begin
      n_fail++; $display("FAIL both_berr got %b want 1", bus_error);
    end
    data_read = 1'b0;
    data_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_halt();
    test_timeout();
    test_reset_mid();
    test_both_error();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
